// File: rtl/fp_norm_shifter.sv
// fp_norm_shifter: two-stage valid/ready normaliser behind the leading-one encoder of the FP add/sub path.
// Optional build macro FP_NORM_STICKY_EN keeps the dropped LSB as a sticky bit on a carry right shift.
module fp_norm_shifter #(
    parameter int WIDTH     = 56,
    parameter int WIDTH_LOG = 6,
    parameter int EXP_W     = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_diff,
    input  logic [WIDTH_LOG-1:0] in_msb,
    input  logic [EXP_W-1:0]     in_exp,
    input  logic                 in_sign,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_mant,
    output logic [EXP_W-1:0]     out_exp,
    output logic                 out_sign,
    output logic                 out_zero,
    output logic                 out_underflow,
    output logic                 out_overflow
);

    localparam int TARGET = WIDTH - 2;
    localparam int SH_W   = WIDTH_LOG + 1;
    localparam int CMP_W  = (EXP_W > SH_W) ? EXP_W : SH_W;

    typedef struct packed {
        logic [SH_W-1:0]  shamt;
        logic             rshift;
        logic [EXP_W-1:0] nexp;
        logic             zero;
        logic             uf;
        logic             of;
    } cls_t;

    function automatic logic [SH_W-1:0] f_lead_zeros(input logic [WIDTH_LOG-1:0] msb);
        return SH_W'(TARGET) - SH_W'(msb);
    endfunction

    // {saturated, exponent}: an all-ones exponent cannot absorb the carry.
    function automatic logic [EXP_W:0] f_exp_inc_sat(input logic [EXP_W-1:0] e);
        if (&e) begin
            return {1'b1, e};
        end
        return {1'b0, e + EXP_W'(1)};
    endfunction

    function automatic cls_t f_classify(input logic [WIDTH-1:0]     diff,
                                        input logic [WIDTH_LOG-1:0] msb,
                                        input logic [EXP_W-1:0]     e);
        cls_t             c;
        logic [SH_W-1:0]  lz;
        logic [EXP_W:0]   inc;
        c   = '0;
        lz  = f_lead_zeros(msb);
        inc = f_exp_inc_sat(e);
        if (diff == '0) begin
            c.zero = 1'b1;
        end else if (msb == WIDTH_LOG'(WIDTH - 1)) begin
            c.rshift = 1'b1;
            c.shamt  = SH_W'(1);
            c.of     = inc[EXP_W];
            c.nexp   = inc[EXP_W-1:0];
        end else if (CMP_W'(lz) <= CMP_W'(e)) begin
            c.shamt = lz;
            c.nexp  = EXP_W'(CMP_W'(e) - CMP_W'(lz));
        end else begin
            // Exponent runs out first: shift only as far as it allows, result is denormal.
            c.shamt = SH_W'(e);
            c.uf    = 1'b1;
        end
        return c;
    endfunction

    function automatic logic [WIDTH-1:0] f_carry_shift(input logic [WIDTH-1:0] diff);
`ifdef FP_NORM_STICKY_EN
        return (diff >> 1) | {{(WIDTH-1){1'b0}}, diff[0]};
`else
        return diff >> 1;
`endif
    endfunction

    function automatic logic [WIDTH-1:0] f_left_shift(input logic [WIDTH-1:0] diff,
                                                      input logic [SH_W-1:0]  shamt);
        logic [WIDTH-1:0] v;
        v = diff;
        for (int i = 0; i < SH_W; i++) begin
            if (shamt[i]) begin
                v = v << (1 << i);
            end
        end
        return v;
    endfunction

    function automatic logic [WIDTH-1:0] f_normalise(input logic [WIDTH-1:0] diff,
                                                     input cls_t             c);
        if (c.of) begin
            return '0;
        end
        if (c.rshift) begin
            return f_carry_shift(diff);
        end
        return f_left_shift(diff, c.shamt);
    endfunction

    logic             w_adv_p1;
    logic             w_adv_p2;
    cls_t             w_cls;
    logic [WIDTH-1:0] w_mant_p1;

    logic             r_vld_p1;
    logic [WIDTH-1:0] r_diff_p1;
    logic             r_sign_p1;
    cls_t             r_cls_p1;

    logic             r_vld_p2;
    logic [WIDTH-1:0] r_mant_p2;
    logic [EXP_W-1:0] r_exp_p2;
    logic             r_sign_p2;
    logic             r_zero_p2;
    logic             r_uf_p2;
    logic             r_of_p2;

    assign w_adv_p2 = !r_vld_p2 || out_ready;
    assign w_adv_p1 = !r_vld_p1 || w_adv_p2;
    assign in_ready = w_adv_p1;

    // Stage 1: classify the difference and work out shift and exponent.
    assign w_cls = f_classify(in_diff, in_msb, in_exp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1  <= 1'b0;
            r_diff_p1 <= '0;
            r_sign_p1 <= 1'b0;
            r_cls_p1  <= '0;
        end else if (w_adv_p1) begin
            r_vld_p1 <= in_valid;
            if (in_valid) begin
                r_diff_p1 <= in_diff;
                r_sign_p1 <= in_sign;
                r_cls_p1  <= w_cls;
            end
        end
    end

    // Stage 2: barrel shift and register the outputs.
    assign w_mant_p1 = f_normalise(r_diff_p1, r_cls_p1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p2  <= 1'b0;
            r_mant_p2 <= '0;
            r_exp_p2  <= '0;
            r_sign_p2 <= 1'b0;
            r_zero_p2 <= 1'b0;
            r_uf_p2   <= 1'b0;
            r_of_p2   <= 1'b0;
        end else if (w_adv_p2) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_mant_p2 <= w_mant_p1;
                r_exp_p2  <= r_cls_p1.nexp;
                r_sign_p2 <= r_sign_p1;
                r_zero_p2 <= r_cls_p1.zero;
                r_uf_p2   <= r_cls_p1.uf;
                r_of_p2   <= r_cls_p1.of;
            end
        end
    end

    assign out_valid     = r_vld_p2;
    assign out_mant      = r_mant_p2;
    assign out_exp       = r_exp_p2;
    assign out_sign      = r_sign_p2;
    assign out_zero      = r_zero_p2;
    assign out_underflow = r_uf_p2;
    assign out_overflow  = r_of_p2;

endmodule

// File: tb/tb_fp_norm_shifter.sv
// Testbench for fp_norm_shifter: directed vectors with literal expectations plus a per-cycle scoreboard.
module tb_fp_norm_shifter;

    localparam int W  = 56;
    localparam int WL = 6;
    localparam int EW = 11;
`ifdef FP_NORM_STICKY_EN
    localparam logic STK = 1'b1;
`else
    localparam logic STK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_diff = '0;
    logic [WL-1:0] in_msb = '0;
    logic [EW-1:0] in_exp = '0;
    logic          in_sign = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_mant;
    logic [EW-1:0] out_exp;
    logic          out_sign;
    logic          out_zero;
    logic          out_underflow;
    logic          out_overflow;

    fp_norm_shifter #(.WIDTH(W), .WIDTH_LOG(WL), .EXP_W(EW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_diff(in_diff), .in_msb(in_msb), .in_exp(in_exp), .in_sign(in_sign),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mant(out_mant), .out_exp(out_exp), .out_sign(out_sign),
        .out_zero(out_zero), .out_underflow(out_underflow), .out_overflow(out_overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]  mant;
        logic [EW-1:0] e;
        logic          sign;
        logic          zero;
        logic          uf;
        logic          of;
    } res_t;

    res_t q[$];
    int   total = 0;
    int   bad = 0;
    int   n_acc = 0;
    int   n_out = 0;

    function automatic res_t mk(logic [W-1:0] m, int e, logic s, logic z, logic u, logic o);
        res_t r;
        r.mant = m; r.e = EW'(e); r.sign = s; r.zero = z; r.uf = u; r.of = o;
        return r;
    endfunction

    // Reference: locate the leading one in the value itself and normalise arithmetically.
    function automatic res_t model(logic [W-1:0] d, int e, logic s);
        res_t r;
        int   p;
        int   lz;
        r = '0;
        r.sign = s;
        if (d == '0) begin
            r.zero = 1'b1;
            return r;
        end
        p = 0;
        for (int i = 0; i < W; i++) if (d[i]) p = i;
        if (p == W - 1) begin
            if (e == (1 << EW) - 1) begin
                r.of = 1'b1;
                r.e  = EW'(e);
            end else begin
                r.mant    = d >> 1;
                r.mant[0] = r.mant[0] | (STK & d[0]);
                r.e       = EW'(e + 1);
            end
        end else begin
            lz = (W - 2) - p;
            if (lz <= e) begin
                r.mant = d << lz;
                r.e    = EW'(e - lz);
            end else begin
                r.mant = d << e;
                r.uf   = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic res_t cur();
        return mk(out_mant, int'(out_exp), out_sign, out_zero, out_underflow, out_overflow);
    endfunction

    task automatic check_res(input string name, input res_t act, input res_t want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got mant=%h exp=%0d s=%b z=%b uf=%b of=%b, want mant=%h exp=%0d s=%b z=%b uf=%b of=%b",
                     name, act.mant, act.e, act.sign, act.zero, act.uf, act.of,
                     want.mant, want.e, want.sign, want.zero, want.uf, want.of);
        end
    endtask

    task automatic check_int(input string name, input int act, input int want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, want);
        end
    endtask

    res_t held;
    bit   have_hold = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            have_hold = 1'b0;
        end else begin
            if (have_hold) begin
                check_int("hold_valid", int'(out_valid), 1);
                check_res("hold_data", cur(), held);
            end
            have_hold = 1'b0;
            if (in_valid && in_ready) begin
                q.push_back(model(in_diff, int'(in_exp), in_sign));
                n_acc++;
            end
            if (out_valid) begin
                if (out_ready) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_out: got mant=%h exp=%0d, want no beat", out_mant, out_exp);
                    end else begin
                        check_res("stream", cur(), q.pop_front());
                    end
                    n_out++;
                end else begin
                    held = cur();
                    have_hold = 1'b1;
                end
            end
        end
    end

    // Drive one beat into an empty pipeline and check the literal result two cycles later.
    task automatic pin(input string name, input logic [W-1:0] d, input int m, input int e,
                       input logic s, input res_t want);
        in_valid = 1'b1; in_diff = d; in_msb = WL'(m); in_exp = EW'(e); in_sign = s;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_int({name, "_lat1"}, int'(out_valid), 0);
        @(negedge clk);
        check_int({name, "_lat2"}, int'(out_valid), 1);
        check_res(name, cur(), want);
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [W-1:0] d, input int m, input int e, input logic s);
        int n;
        in_valid = 1'b1; in_diff = d; in_msb = WL'(m); in_exp = EW'(e); in_sign = s;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (n >= 40) check_int("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_acc;
        int base_out;
        repeat (2) @(negedge clk);
        check_int("reset_out_valid", int'(out_valid), 0);
        check_res("reset_data", cur(), '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_int("in_ready_after_reset", int'(in_ready), 1);
        @(posedge clk); #1;

        pin("lshift54", 56'h1, 0, 100, 1'b0, mk(56'h40_0000_0000_0000, 46, 0, 0, 0, 0));
        pin("lshift49", 56'h20, 5, 100, 1'b0, mk(56'h40_0000_0000_0000, 51, 0, 0, 0, 0));
        pin("carry_sticky", 56'h80_0000_0000_0001, 55, 100, 1'b0,
            mk(56'h40_0000_0000_0000 | 56'(STK), 101, 0, 0, 0, 0));
        pin("zero", 56'h0, 0, 77, 1'b1, mk('0, 0, 1, 1, 0, 0));
        pin("overflow", 56'h80_0000_0000_0000, 55, 2047, 1'b0, mk('0, 2047, 0, 0, 0, 1));
        pin("underflow", 56'h1, 0, 10, 1'b0, mk(56'h400, 0, 0, 0, 1, 0));
        pin("passthru", 56'h40_0000_0000_0123, 54, 5, 1'b1, mk(56'h40_0000_0000_0123, 5, 1, 0, 0, 0));
        pin("lz_eq_exp", 56'h4_0000_0000_0000, 50, 4, 1'b0, mk(56'h40_0000_0000_0000, 0, 0, 0, 0, 0));
        pin("uf_exp0", 56'h8, 3, 0, 1'b0, mk(56'h8, 0, 0, 0, 1, 0));
        pin("carry_to_max", 56'h80_0000_0000_0002, 55, 2046, 1'b0, mk(56'h40_0000_0000_0001, 2047, 0, 0, 0, 0));
        pin("zero_priority", 56'h0, 55, 2047, 1'b0, mk('0, 0, 0, 1, 0, 0));

        // Backpressure: four back-to-back beats, consumer stalled for five cycles.
        out_ready = 1'b0;
        base_acc = n_acc;
        base_out = n_out;
        fork
            begin
                send(56'h20, 5, 100, 1'b0);
                send(56'h1, 0, 10, 1'b1);
                send(56'h80_0000_0000_0001, 55, 300, 1'b0);
                send(56'h0, 0, 9, 1'b1);
            end
            begin
                repeat (5) @(negedge clk);
                #1;
                check_int("bp_accepted", n_acc - base_acc, 2);
                check_int("bp_in_ready_low", int'(in_ready), 0);
                check_int("bp_no_output", n_out - base_out, 0);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #1;
        check_int("bp_all_out", n_out - base_out, 4);
        check_int("bp_queue_empty", q.size(), 0);

        // Reset with two beats in flight.
        out_ready = 1'b0;
        send(56'h1, 0, 100, 1'b0);
        send(56'h20, 5, 100, 1'b1);
        rst = 1'b1;
        #1;
        check_int("rst_async_out_valid", int'(out_valid), 0);
        check_res("rst_async_data", cur(), '0);
        @(posedge clk); #1;
        rst = 1'b0;
        check_int("in_ready_after_rst", int'(in_ready), 1);
        out_ready = 1'b1;
        base_out = n_out;
        repeat (6) @(posedge clk);
        #1;
        check_int("rst_no_ghost", n_out - base_out, 0);
        check_int("final_queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
